stim_dac: RTL and testbench
===========================

Name: stim_dac

Overview:
- Playback stimulus source for the emulator; the drive-side counterpart of the per-signal probe that samples (time, value) pairs to a file.
- A testbench or host loads (time, value) pairs through a valid/ready port into an on-chip FIFO.
- The block then drives a signed fixed-point signal that changes to each stored value when the emulated time reaches that entry's timestamp.
- Drives analog-model inputs such as channel stimulus and supply noise.

Parameters:
- sig_bits, 16, width of the signed output value.
- sig_point, 14, binary point of the value (informational; no arithmetic applied).
- depth_log2, 4, FIFO depth = 2**depth_log2 entries (range 1..8).
- init_val, 0, value of sig at reset and after flush.

Ports:
- clk  input  1  system clock
- rst_n  input  1  asynchronous active-low reset
- time_curr  input  TIME_FORMAT  current emulated time (unsigned, TIME_POINT fractional bits)
- in_valid  input  1  load entry present
- in_ready  output  1  FIFO can accept an entry
- in_time  input  TIME_FORMAT  entry timestamp
- in_val  input  sig_bits  entry value (signed)
- run  input  1  playback enable
- flush  input  1  synchronous clear of FIFO and output
- sig  output  sig_bits  driven signed value
- upd  output  1  one-cycle pulse when sig was updated
- count  output  depth_log2+1  FIFO occupancy
- empty  output  1  count==0

Behaviour:
- Reset (rst_n=0, async): pointers=0, count=0, empty=1, in_ready=1, sig=init_val, upd=0.
- FIFO storage uses wr/rd pointers with one extra wrap bit.
  - full = MSBs differ and the low bits are equal.
  - in_ready = !full. Pointers wrap modulo 2**(depth_log2+1).
- Push: in_valid && in_ready at posedge writes {in_time, in_val} at wr_ptr and increments wr_ptr.
- Pop condition: run && !empty && (time_curr >= head_time), unsigned compare.
- On pop at posedge:
  - sig <= head_val, upd <= 1, rd_ptr increments.
  - Latency: 1 cycle from the first cycle the condition is true to sig/upd visible.
- Otherwise upd <= 0 and sig holds.
- At most one pop per cycle. Entries whose times are all already passed drain one per cycle in FIFO order. sig ends at the last value, and each drained entry produces an upd pulse.
- Non-monotonic timestamps are legal. An entry earlier than its predecessor pops on the cycle after the predecessor (no reordering).
- Simultaneous push and pop: both occur.
  - count unchanged.
  - in_ready is computed from the pre-edge count, so a full FIFO does not accept the push even while popping.
- Push into an empty FIFO: the entry becomes eligible for pop the following cycle (no same-cycle bypass).
- run=0: no pops; sig holds; loading still allowed.
- flush=1 (sync):
  - Pointers/count cleared, sig <= init_val, upd <= 0.
  - Overrides push and pop in the same cycle.
- Reset mid-playback: all state returns to reset values immediately; partial entries are discarded.
- State summary:
  - EMPTY: count==0.
  - WAIT: !empty and (!run or time_curr < head_time).
  - FIRE: pop condition true.
  - FIRE→FIRE while successive heads are due; FIRE→WAIT or EMPTY otherwise.
- No arithmetic on values; sig_point only documents the format.

Optional Feature:
- Macro STIM_DAC_LATE_CNT_EN.
- When defined, adds output late_cnt (16 bits, reset 0, cleared by flush).
- late_cnt increments on each pop where time_curr > head_time (strictly late) and saturates at 16'hFFFF.
- When undefined, the port and counter are absent.
- All other behaviour is identical in both cases.

Test Plan:
- Reset with init_val=0 → sig=0, upd=0, empty=1, in_ready=1, count=0.
- run=1, load (t=100,v=5),(t=200,v=-3), time_curr stepping +10/cycle from 0:
  - sig=5 with one upd pulse the cycle after time_curr reaches 100.
  - sig=-3 the cycle after time_curr reaches 200.
  - empty=1 after the second pop.
- run=0, fill 16 entries (depth_log2=4) → in_ready=0, count=16, and a 17th in_valid is not accepted.
- Then run=1 with time_curr=1000 and all timestamps below 1000:
  - 16 consecutive upd pulses.
  - sig = last loaded value.
  - count decrements by 1 per cycle to 0.
- FIFO full, pop and push in the same cycle → push refused, count=15 afterwards. Next cycle the push is accepted and count=16 again (if no pop).
- Loaded entries with sig=7, assert flush with in_valid=1 → count=0, sig=init_val, entry not written. rst_n pulsed low mid-drain → immediate sig=init_val, count=0.
- With STIM_DAC_LATE_CNT_EN: entry t=50 popped at time_curr=80 → late_cnt=1. Entry t=90 popped at time_curr=90 → late_cnt stays 1.

Source files
------------

// File: rtl/stim_dac.sv
`default_nettype none
// ============================================================================
// Module   : stim_dac
// Purpose  : Playback stimulus source. This block accepts (time, value) pairs
//            through a valid/ready port and stores them in a FIFO. It drives
//            a signed fixed-point signal. The signal takes each stored value
//            one cycle after the emulated time reaches that entry's
//            timestamp.
// Options  : STIM_DAC_LATE_CNT_EN adds the late_cnt output. This is a
//            saturating count of pops whose timestamp had already passed.
// Revision : 1.0 - initial release
// ============================================================================
module stim_dac #(
  parameter int                         SIG_BITS   = 16,
  parameter int                         SIG_POINT  = 14,
  parameter int                         DEPTH_LOG2 = 4,
  parameter int                         TIME_BITS  = 32,
  parameter int                         TIME_POINT = 16,
  parameter logic signed [SIG_BITS-1:0] INIT_VAL   = '0
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [TIME_BITS-1:0]  time_curr,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [TIME_BITS-1:0]  in_time,
  input  logic [SIG_BITS-1:0]   in_val,
  input  logic                  run,
  input  logic                  flush,
  output logic [SIG_BITS-1:0]   sig,
  output logic                  upd,
  output logic [DEPTH_LOG2:0]   count,
  output logic                  empty
`ifdef STIM_DAC_LATE_CNT_EN
  ,
  output logic [15:0]           late_cnt
`endif
);

  localparam int                  c_DEPTH   = 1 << DEPTH_LOG2;
  localparam int                  c_ENT_W   = TIME_BITS + SIG_BITS;
  localparam logic [DEPTH_LOG2:0] c_PTR_ONE = 1;

  // The fixed-point format parameters are descriptive only; reject
  // nonsensical combinations at elaboration.
  if (DEPTH_LOG2 < 1 || DEPTH_LOG2 > 8 || SIG_POINT >= SIG_BITS ||
      TIME_POINT > TIME_BITS) begin : g_bad_param
    $error("stim_dac: illegal parameter combination");
  end

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_WAIT  = 2'd1,
    ST_FIRE  = 2'd2
  } state_e;

  logic [c_ENT_W-1:0]   mem_q [c_DEPTH];
  logic [DEPTH_LOG2:0]  wr_ptr_q, wr_ptr_d;
  logic [DEPTH_LOG2:0]  rd_ptr_q, rd_ptr_d;
  logic [SIG_BITS-1:0]  sig_q, sig_d;
  logic                 upd_q, upd_d;

  logic [c_ENT_W-1:0]   w_head;
  logic [TIME_BITS-1:0] w_head_time;
  logic [SIG_BITS-1:0]  w_head_val;
  logic                 w_full;
  logic                 w_empty;
  logic                 w_push;
  logic                 w_pop;
  state_e               w_state;

  // The extra pointer bit distinguishes full (laps differ) from empty.
  assign w_empty     = (wr_ptr_q == rd_ptr_q);
  assign w_full      = (wr_ptr_q[DEPTH_LOG2] != rd_ptr_q[DEPTH_LOG2]) &&
                       (wr_ptr_q[DEPTH_LOG2-1:0] == rd_ptr_q[DEPTH_LOG2-1:0]);
  assign w_head      = mem_q[rd_ptr_q[DEPTH_LOG2-1:0]];
  assign w_head_time = w_head[c_ENT_W-1:SIG_BITS];
  assign w_head_val  = w_head[SIG_BITS-1:0];
  assign w_push      = in_valid && !w_full;
  assign w_pop       = (w_state == ST_FIRE);

  // This logic classifies the playback state from the FIFO head and
  // the emulated time.
  always_comb begin
    w_state = ST_EMPTY;
    if (!w_empty) begin
      if (run && (time_curr >= w_head_time)) begin
        w_state = ST_FIRE;
      end else begin
        w_state = ST_WAIT;
      end
    end
  end

  // This logic computes the next pointers and output. Flush takes
  // priority over push and pop.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    sig_d    = sig_q;
    upd_d    = 1'b0;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      sig_d    = INIT_VAL;
    end else begin
      if (w_push) begin
        wr_ptr_d = wr_ptr_q + c_PTR_ONE;
      end
      if (w_pop) begin
        rd_ptr_d = rd_ptr_q + c_PTR_ONE;
        sig_d    = w_head_val;
        upd_d    = 1'b1;
      end
    end
  end

  // This register holds the pointers and driven value, with async clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      sig_q    <= INIT_VAL;
      upd_q    <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      sig_q    <= sig_d;
      upd_q    <= upd_d;
    end
  end

  // FIFO storage has no reset. Pointers alone define which entries are valid.
  always_ff @(posedge clk) begin
    if (w_push && !flush) begin
      mem_q[wr_ptr_q[DEPTH_LOG2-1:0]] <= {in_time, in_val};
    end
  end

  assign in_ready = !w_full;
  assign sig      = sig_q;
  assign upd      = upd_q;
  assign count    = wr_ptr_q - rd_ptr_q;
  assign empty    = w_empty;

`ifdef STIM_DAC_LATE_CNT_EN
  logic [15:0] late_q, late_d;

  // This logic counts strictly late pops and saturates at all-ones.
  always_comb begin
    late_d = late_q;
    if (flush) begin
      late_d = '0;
    end else if (w_pop && (time_curr > w_head_time) && (late_q != 16'hFFFF)) begin
      late_d = late_q + 16'd1;
    end
  end

  // This register holds the late-pop counter, with async clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      late_q <= '0;
    end else begin
      late_q <= late_d;
    end
  end

  assign late_cnt = late_q;
`endif

endmodule
`default_nettype wire

// File: tb/tb_stim_dac.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tb_stim_dac
// Purpose  : Self-checking bench for stim_dac. Checks use a queue-based
//            playback model. The bench also checks STIM_DAC_LATE_CNT_EN
//            when that macro is defined.
// Revision : 1.0 - initial release
// ============================================================================
module tb_stim_dac;

  localparam int          DEPTH = 16;
  localparam logic [15:0] INIT  = 16'h0000;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [31:0] time_curr = '0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] in_time = '0;
  logic [15:0] in_val = '0;
  logic        run = 1'b0;
  logic        flush = 1'b0;
  logic [15:0] sig;
  logic        upd;
  logic [4:0]  count;
  logic        empty;
`ifdef STIM_DAC_LATE_CNT_EN
  logic [15:0] late_cnt;
`endif

  stim_dac dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .time_curr (time_curr),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_time   (in_time),
    .in_val    (in_val),
    .run       (run),
    .flush     (flush),
    .sig       (sig),
    .upd       (upd),
    .count     (count),
    .empty     (empty)
`ifdef STIM_DAC_LATE_CNT_EN
    ,
    .late_cnt  (late_cnt)
`endif
  );

  always #5 clk = ~clk;

  // Reference model: a queue of pending entries plus the driven value.
  typedef struct packed {
    logic [31:0] t;
    logic [15:0] v;
  } ent_t;

  ent_t        mq[$];
  logic [15:0] m_sig  = INIT;
  logic        m_upd  = 1'b0;
  logic [15:0] m_late = '0;
  int          total  = 0;
  int          bad    = 0;

  logic [23:0] obs;
  assign obs = {sig, upd, count, empty, in_ready};

  function automatic logic [23:0] m_vec();
    int n = mq.size();
    return {m_sig, m_upd, 5'(n), (n == 0), (n < DEPTH)};
  endfunction

  task automatic m_reset();
    mq.delete();
    m_sig  = INIT;
    m_upd  = 1'b0;
    m_late = '0;
  endtask

  // Advance one clock edge, apply the playback rules to the model, and settle.
  task automatic tick();
    bit do_push, do_pop;
    @(posedge clk);
    if (flush) begin
      m_reset();
    end else begin
      do_push = in_valid && (mq.size() < DEPTH);
      do_pop  = run && (mq.size() > 0) && (time_curr >= mq[0].t);
      m_upd   = do_pop;
      if (do_pop) begin
        m_sig = mq[0].v;
        if (time_curr > mq[0].t && m_late != 16'hFFFF) m_late = m_late + 16'd1;
        void'(mq.pop_front());
      end
      if (do_push) mq.push_back({in_time, in_val});
    end
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    #1;
    m_reset();
    total++;
    if (obs !== {16'h0000, 1'b0, 5'd0, 1'b1, 1'b1}) begin
      bad++;
      $display("FAIL reset_state: got %h want %h", obs, {16'h0000, 1'b0, 5'd0, 1'b1, 1'b1});
    end
`ifdef STIM_DAC_LATE_CNT_EN
    total++;
    if (late_cnt !== 16'd0) begin
      bad++;
      $display("FAIL reset_late: got %0d want 0", late_cnt);
    end
`endif
    #2 rst_n = 1'b1;
  endtask

  task automatic test_basic();
    run = 1'b1; time_curr = 0;
    in_valid = 1'b1; in_time = 100; in_val = 16'd5;
    tick();
    in_time = 200; in_val = 16'hFFFD;
    tick();
    in_valid = 1'b0;
    for (int k = 0; k <= 25; k++) begin
      time_curr = 32'(k * 10);
      tick();
      total++;
      if (obs !== m_vec()) begin
        bad++;
        $display("FAIL basic_k%0d: got %h want %h", k, obs, m_vec());
      end
      if (k == 9 || k == 10 || k == 20) begin
        total++;
        if ({sig, upd} !== (k == 9 ? {16'd0, 1'b0} : (k == 10 ? {16'd5, 1'b1} : {16'hFFFD, 1'b1}))) begin
          bad++;
          $display("FAIL basic_pop_k%0d: got sig=%h upd=%b", k, sig, upd);
        end
      end
    end
    total++;
    if (empty !== 1'b1 || sig !== 16'hFFFD) begin
      bad++;
      $display("FAIL basic_end: got empty=%b sig=%h want 1 fffd", empty, sig);
    end
  endtask

  // Fill the FIFO with timestamps below 1000 while playback is stopped.
  task automatic fill(input int n, output logic [15:0] last);
    run = 1'b0; in_valid = 1'b1;
    last = '0;
    for (int i = 0; i < n; i++) begin
      in_time = $urandom_range(0, 999);
      in_val  = 16'($urandom);
      last    = in_val;
      tick();
      total++;
      if (obs !== m_vec()) begin
        bad++;
        $display("FAIL fill_%0d: got %h want %h", i, obs, m_vec());
      end
    end
    in_valid = 1'b0;
  endtask

  task automatic test_fill_drain();
    logic [15:0] last;
    fill(DEPTH, last);
    in_valid = 1'b1; in_time = 5; in_val = 16'hBEEF;
    total++;
    if ({in_ready, count} !== {1'b0, 5'd16}) begin
      bad++;
      $display("FAIL full_flags: got ready=%b count=%0d want 0 16", in_ready, count);
    end
    tick();
    in_valid = 1'b0;
    total++;
    if (count !== 5'd16 || obs !== m_vec()) begin
      bad++;
      $display("FAIL full_17th: got count=%0d want 16", count);
    end
    run = 1'b1; time_curr = 1000;
    for (int i = 0; i < DEPTH; i++) begin
      tick();
      total++;
      if ({upd, count} !== {1'b1, 5'(15 - i)} || obs !== m_vec()) begin
        bad++;
        $display("FAIL drain_%0d: got upd=%b count=%0d want 1 %0d", i, upd, count, 15 - i);
      end
    end
    total++;
    if (sig !== last) begin
      bad++;
      $display("FAIL drain_last: got %h want %h", sig, last);
    end
    tick();
    total++;
    if ({upd, empty} !== 2'b01) begin
      bad++;
      $display("FAIL drain_idle: got upd=%b empty=%b want 0 1", upd, empty);
    end
  endtask

  task automatic test_full_pushpop();
    logic [15:0] last;
    time_curr = 1000;
    fill(DEPTH, last);
    run = 1'b1; in_valid = 1'b1; in_time = 5; in_val = 16'h1234;
    tick();
    total++;
    if (count !== 5'd15 || obs !== m_vec()) begin
      bad++;
      $display("FAIL pushpop_full: got count=%0d want 15", count);
    end
    run = 1'b0;
    tick();
    in_valid = 1'b0;
    total++;
    if (count !== 5'd16 || obs !== m_vec()) begin
      bad++;
      $display("FAIL pushpop_next: got count=%0d want 16", count);
    end
    flush = 1'b1;
    tick();
    flush = 1'b0;
  endtask

  task automatic test_flush();
    run = 1'b1; time_curr = 1000;
    in_valid = 1'b1; in_time = 10; in_val = 16'd7;
    tick();
    in_valid = 1'b0;
    tick();
    total++;
    if (sig !== 16'd7) begin
      bad++;
      $display("FAIL flush_pre: got sig=%h want 0007", sig);
    end
    run = 1'b0; in_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      in_time = 32'(20 + i); in_val = 16'(i + 1);
      tick();
    end
    flush = 1'b1; in_time = 30; in_val = 16'h5555;
    tick();
    total++;
    if ({count, sig} !== {5'd0, INIT} || obs !== m_vec()) begin
      bad++;
      $display("FAIL flush_apply: got count=%0d sig=%h want 0 %h", count, sig, INIT);
    end
    flush = 1'b0; in_valid = 1'b0; run = 1'b1;
    tick();
    total++;
    if ({empty, count, upd} !== {1'b1, 5'd0, 1'b0}) begin
      bad++;
      $display("FAIL flush_nowrite: got empty=%b count=%0d upd=%b", empty, count, upd);
    end
  endtask

  task automatic test_reset_mid();
    logic [15:0] last;
    fill(8, last);
    run = 1'b1; time_curr = 1000;
    for (int i = 0; i < 3; i++) tick();
    #2 rst_n = 1'b0;
    #1;
    m_reset();
    total++;
    if ({sig, count, upd, empty} !== {INIT, 5'd0, 1'b0, 1'b1}) begin
      bad++;
      $display("FAIL reset_mid: got sig=%h count=%0d upd=%b", sig, count, upd);
    end
    run = 1'b0;
    #1 rst_n = 1'b1;
  endtask

`ifdef STIM_DAC_LATE_CNT_EN
  task automatic test_late();
    flush = 1'b1;
    tick();
    flush = 1'b0; run = 1'b0; time_curr = 0; in_valid = 1'b1;
    in_time = 50; in_val = 16'd1;
    tick();
    in_time = 90; in_val = 16'd2;
    tick();
    in_valid = 1'b0; run = 1'b1; time_curr = 80;
    tick();
    total++;
    if (late_cnt !== 16'd1 || sig !== 16'd1) begin
      bad++;
      $display("FAIL late_first: got late=%0d sig=%h want 1 0001", late_cnt, sig);
    end
    time_curr = 90;
    tick();
    total++;
    if (late_cnt !== 16'd1 || sig !== 16'd2) begin
      bad++;
      $display("FAIL late_ontime: got late=%0d sig=%h want 1 0002", late_cnt, sig);
    end
  endtask
`endif

  task automatic test_random();
    logic [31:0] tc;
    tc = time_curr;
    for (int c = 0; c < 400; c++) begin
      tc        = tc + $urandom_range(0, 20);
      time_curr = tc;
      in_valid  = ($urandom_range(0, 2) != 0);
      in_time   = (tc > 50 ? tc - 50 : 0) + $urandom_range(0, 200);
      in_val    = 16'($urandom);
      run       = ($urandom_range(0, 9) != 0);
      flush     = ($urandom_range(0, 60) == 0);
      tick();
      total++;
      if (obs !== m_vec()) begin
        bad++;
        $display("FAIL random_%0d: got %h want %h", c, obs, m_vec());
      end
`ifdef STIM_DAC_LATE_CNT_EN
      total++;
      if (late_cnt !== m_late) begin
        bad++;
        $display("FAIL random_late_%0d: got %0d want %0d", c, late_cnt, m_late);
      end
`endif
    end
    in_valid = 1'b0; flush = 1'b0;
  endtask

  initial begin
    test_reset();
    test_basic();
    test_fill_drain();
    test_full_pushpop();
    test_flush();
    test_reset_mid();
`ifdef STIM_DAC_LATE_CNT_EN
    test_late();
`endif
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
